// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared opcodes, T-state constants and control word for the SAP-U sequencer
package sap_pkg;

    localparam int OPCODE_W  = 4;
    localparam int NUM_STEPS = 5;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'(NUM_STEPS - 1);

    typedef struct packed {
        logic mar_in_n;
        logic ram_in_n;
        logic ram_out_n;
        logic ir_in_n;
        logic ir_out_n;
        logic a_in_n;
        logic a_out_n;
        logic b_in_n;
        logic alu_out_n;
        logic flags_in_n;
        logic out_in_n;
        logic alu_sub;
        logic pc_enable;
        logic pc_out_n;
        logic jump_n;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        mar_in_n: 1'b1, ram_in_n: 1'b1, ram_out_n: 1'b1, ir_in_n: 1'b1,
        ir_out_n: 1'b1, a_in_n: 1'b1, a_out_n: 1'b1, b_in_n: 1'b1,
        alu_out_n: 1'b1, flags_in_n: 1'b1, out_in_n: 1'b1, alu_sub: 1'b0,
        pc_enable: 1'b0, pc_out_n: 1'b1, jump_n: 1'b1
    };

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - falling-edge T-state counter with early return and hold
import sap_pkg::*;

module step_counter (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       ret_zero,
    input  logic       hold,
    output logic [2:0] step
);

    logic [2:0] step_q;
    logic [2:0] step_d;

    always_comb begin
        step_d = step_q;
        if (!hold) begin
            if (ret_zero || step_q >= T4) begin
                step_d = T0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    always_ff @(negedge clk or negedge clear_n) begin
        if (!clear_n) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - SAP-U microcode decode, halt register and step sequencing
import sap_pkg::*;

module control_sequencer (
    input  logic                clk,
    input  logic                clear_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic [2:0]          step,
    output logic                hlt,
    output logic                mar_in_n,
    output logic                ram_in_n,
    output logic                ram_out_n,
    output logic                ir_in_n,
    output logic                ir_out_n,
    output logic                a_in_n,
    output logic                a_out_n,
    output logic                b_in_n,
    output logic                alu_out_n,
    output logic                flags_in_n,
    output logic                out_in_n,
    output logic                alu_sub,
    output logic                pc_enable,
    output logic                pc_out_n,
    output logic                jump_n
);

    logic       hlt_q, hlt_d;
    logic       armed_q, armed_d;
    logic [2:0] step_q;
    logic [2:0] last_step;
    logic       hlt_set;
    ctrl_t      cw;
    ctrl_t      cw_out;

    // The first falling edge after reset release only arms the sequencer so T0 gets a full rising edge.
    step_counter u_step_counter (
        .clk      (clk),
        .clear_n  (clear_n),
        .ret_zero (step_q == last_step),
        .hold     (hlt_q || !armed_q),
        .step     (step_q)
    );

    always_comb begin
        cw        = CTRL_IDLE;
        last_step = T1;
        hlt_set   = 1'b0;
        case (opcode)
            OP_LDA:         last_step = T3;
            OP_STA:         last_step = T3;
            OP_ADD, OP_SUB: last_step = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = T2;
            default:        last_step = T1;
        endcase
        if (step_q == T0) begin
            cw.pc_out_n = 1'b0;
            cw.mar_in_n = 1'b0;
        end else if (step_q == T1) begin
            cw.ram_out_n = 1'b0;
            cw.ir_in_n   = 1'b0;
            cw.pc_enable = 1'b1;
        end else begin
            case (opcode)
                OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                    if (step_q == T2) begin
                        cw.ir_out_n = 1'b0;
                        cw.mar_in_n = 1'b0;
                    end else if (step_q == T3) begin
                        cw.alu_sub = (opcode == OP_SUB);
                        if (opcode == OP_LDA) begin
                            cw.ram_out_n = 1'b0;
                            cw.a_in_n    = 1'b0;
                        end else if (opcode == OP_STA) begin
                            cw.a_out_n  = 1'b0;
                            cw.ram_in_n = 1'b0;
                        end else begin
                            cw.ram_out_n = 1'b0;
                            cw.b_in_n    = 1'b0;
                        end
                    end else if (step_q == T4 && (opcode == OP_ADD || opcode == OP_SUB)) begin
                        cw.alu_sub    = (opcode == OP_SUB);
                        cw.alu_out_n  = 1'b0;
                        cw.a_in_n     = 1'b0;
                        cw.flags_in_n = 1'b0;
                    end
                end
                OP_LDI: if (step_q == T2) begin
                    cw.ir_out_n = 1'b0;
                    cw.a_in_n   = 1'b0;
                end
                OP_JMP, OP_JC, OP_JZ: begin
                    if (step_q == T2 && (opcode == OP_JMP || (opcode == OP_JC && carry_flag)
                                         || (opcode == OP_JZ && zero_flag))) begin
                        cw.ir_out_n = 1'b0;
                        cw.jump_n   = 1'b0;
                    end
                end
                OP_OUT: if (step_q == T2) begin
                    cw.a_out_n  = 1'b0;
                    cw.out_in_n = 1'b0;
                end
                OP_HLT: hlt_set = (step_q == T2);
                default: ;
            endcase
        end
        cw_out = (!clear_n || hlt_q) ? CTRL_IDLE : cw;
    end

    always_comb begin
        armed_d = 1'b1;
        hlt_d   = hlt_q | (hlt_set & armed_q);
    end

    always_ff @(negedge clk or negedge clear_n) begin
        if (!clear_n) begin
            hlt_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            hlt_q   <= hlt_d;
            armed_q <= armed_d;
        end
    end

    assign step       = step_q;
    assign hlt        = hlt_q;
    assign mar_in_n   = cw_out.mar_in_n;
    assign ram_in_n   = cw_out.ram_in_n;
    assign ram_out_n  = cw_out.ram_out_n;
    assign ir_in_n    = cw_out.ir_in_n;
    assign ir_out_n   = cw_out.ir_out_n;
    assign a_in_n     = cw_out.a_in_n;
    assign a_out_n    = cw_out.a_out_n;
    assign b_in_n     = cw_out.b_in_n;
    assign alu_out_n  = cw_out.alu_out_n;
    assign flags_in_n = cw_out.flags_in_n;
    assign out_in_n   = cw_out.out_in_n;
    assign alu_sub    = cw_out.alu_sub;
    assign pc_enable  = cw_out.pc_enable;
    assign pc_out_n   = cw_out.pc_out_n;
    assign jump_n     = cw_out.jump_n;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized and directed check of control_sequencer against a microprogram table model
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [3:0] opcode;
    logic       carry_flag, zero_flag;
    logic [2:0] step;
    logic       hlt;
    logic mar_in_n, ram_in_n, ram_out_n, ir_in_n, ir_out_n, a_in_n, a_out_n, b_in_n;
    logic alu_out_n, flags_in_n, out_in_n, alu_sub, pc_enable, pc_out_n, jump_n;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clear_n(clear_n), .opcode(opcode), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .step(step), .hlt(hlt), .mar_in_n(mar_in_n),
        .ram_in_n(ram_in_n), .ram_out_n(ram_out_n), .ir_in_n(ir_in_n), .ir_out_n(ir_out_n),
        .a_in_n(a_in_n), .a_out_n(a_out_n), .b_in_n(b_in_n), .alu_out_n(alu_out_n),
        .flags_in_n(flags_in_n), .out_in_n(out_in_n), .alu_sub(alu_sub),
        .pc_enable(pc_enable), .pc_out_n(pc_out_n), .jump_n(jump_n)
    );

    // Bit positions of the "strobe is active" mask, polarity removed.
    localparam int I_MAR = 0, I_RAMIN = 1, I_RAMOUT = 2, I_IRIN = 3, I_IROUT = 4;
    localparam int I_AIN = 5, I_AOUT = 6, I_BIN = 7, I_ALUOUT = 8, I_FLAGS = 9;
    localparam int I_OUTIN = 10, I_SUB = 11, I_PCEN = 12, I_PCOUT = 13, I_JMP = 14;

    wire [14:0] act = {~jump_n, ~pc_out_n, pc_enable, alu_sub, ~out_in_n, ~flags_in_n,
                       ~alu_out_n, ~b_in_n, ~a_out_n, ~a_in_n, ~ir_out_n, ~ir_in_n,
                       ~ram_out_n, ~ram_in_n, ~mar_in_n};

    int total = 0;
    int bad   = 0;

    logic [14:0] ucode [16][5];
    int          len [16];
    int          m_step;
    bit          m_hlt, m_armed;

    function automatic logic [14:0] b(input int i);
        logic [14:0] one;
        one = 15'd1;
        return one << i;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic build_ucode();
        for (int op = 0; op < 16; op++) begin
            for (int s = 0; s < 5; s++) ucode[op][s] = '0;
            ucode[op][0] = b(I_PCOUT) | b(I_MAR);
            ucode[op][1] = b(I_RAMOUT) | b(I_IRIN) | b(I_PCEN);
            len[op] = 2;
        end
        ucode[1][2] = b(I_IROUT) | b(I_MAR);   ucode[1][3] = b(I_RAMOUT) | b(I_AIN);   len[1] = 4;
        for (int op = 2; op <= 3; op++) begin
            ucode[op][2] = b(I_IROUT) | b(I_MAR);
            ucode[op][3] = b(I_RAMOUT) | b(I_BIN) | ((op == 3) ? b(I_SUB) : 15'd0);
            ucode[op][4] = b(I_ALUOUT) | b(I_AIN) | b(I_FLAGS) | ((op == 3) ? b(I_SUB) : 15'd0);
            len[op] = 5;
        end
        ucode[4][2] = b(I_IROUT) | b(I_MAR);   ucode[4][3] = b(I_AOUT) | b(I_RAMIN);   len[4] = 4;
        ucode[5][2] = b(I_IROUT) | b(I_AIN);   len[5] = 3;
        for (int op = 6; op <= 8; op++) begin
            ucode[op][2] = b(I_IROUT) | b(I_JMP); len[op] = 3;
        end
        ucode[14][2] = b(I_AOUT) | b(I_OUTIN); len[14] = 3;
        len[15] = 3;
    endtask

    // Advance the model on a falling edge using the inputs held before the edge.
    task automatic model_edge();
        if (!clear_n) begin
            m_step = 0; m_hlt = 0; m_armed = 0;
        end else if (!m_armed) begin
            m_armed = 1;
        end else if (!m_hlt) begin
            if (opcode == 4'hF && m_step == 2) begin
                m_hlt = 1; m_step = 0;
            end else if (m_step == len[opcode] - 1 || m_step == 4) begin
                m_step = 0;
            end else begin
                m_step++;
            end
        end
    endtask

    task automatic compare();
        logic [14:0] exp_mask;
        if (!clear_n) begin
            m_step = 0; m_hlt = 0; m_armed = 0;
        end
        exp_mask = ucode[opcode][m_step];
        if (!clear_n || m_hlt) exp_mask = '0;
        if (m_step == 2 && ((opcode == 4'h7 && !carry_flag) || (opcode == 4'h8 && !zero_flag)))
            exp_mask = '0;
        check("step", int'(step), m_step);
        check("hlt", int'(hlt), int'(m_hlt));
        check("strobes", int'(act), int'(exp_mask));
    endtask

    task automatic tick(input logic [3:0] op, input logic c, input logic z, input logic cl);
        @(negedge clk);
        model_edge();
        #1;
        opcode = op; carry_flag = c; zero_flag = z; clear_n = cl;
        #2;
        compare();
    endtask

    int halt_cnt;

    initial begin
        build_ucode();
        clear_n = 1'b0; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
        m_step = 0; m_hlt = 0; m_armed = 0;
        #3;
        check("rst_step", int'(step), 0);
        check("rst_hlt", int'(hlt), 0);
        check("rst_pc_enable", int'(pc_enable), 0);
        check("rst_mar_in_n", int'(mar_in_n), 1);
        for (int i = 0; i < 3; i++) tick(4'h1, 1'b0, 1'b0, 1'b0);
        check("rst_idle_mask", int'(act), 0);

        tick(4'h1, 1'b0, 1'b0, 1'b1);
        check("release_fetch", int'({pc_out_n, mar_in_n}), 0);
        tick(4'h1, 1'b0, 1'b0, 1'b1);
        check("arm_step", int'(step), 0);

        // LDA: steps 1,2,3,0
        for (int k = 1; k <= 4; k++) begin
            tick(4'h1, 1'b0, 1'b0, 1'b1);
            check("lda_step", int'(step), k % 4);
            check("lda_pc_enable", int'(pc_enable), (k == 1) ? 1 : 0);
            check("lda_ram_a", int'({ram_out_n, a_in_n}), (k == 3) ? 0 : ((k == 1) ? 1 : 3));
        end
        // SUB: five-cycle instruction
        for (int k = 1; k <= 5; k++) begin
            tick(4'h3, 1'b0, 1'b0, 1'b1);
            check("sub_step", int'(step), k % 5);
            check("sub_alu_sub", int'(alu_sub), (k == 3 || k == 4) ? 1 : 0);
            check("sub_flags_alu", int'({flags_in_n, alu_out_n}), (k == 4) ? 0 : 3);
        end
        // Conditional jumps, flag clear then set
        for (int j = 0; j < 4; j++) begin
            logic [3:0] op;
            logic       f;
            op = (j < 2) ? 4'h7 : 4'h8;
            f  = j[0];
            for (int k = 1; k <= 3; k++) begin
                tick(op, (op == 4'h7) ? f : ~f, (op == 4'h8) ? f : ~f, 1'b1);
                check("jcc_step", int'(step), k % 3);
                if (k == 2) check("jcc_jump", int'({jump_n, ir_out_n}), f ? 0 : 3);
            end
        end
        // HLT then ten frozen clocks
        for (int k = 1; k <= 3; k++) tick(4'hF, 1'b0, 1'b0, 1'b1);
        check("hlt_set", int'(hlt), 1);
        for (int k = 0; k < 10; k++) begin
            tick(4'h1, 1'b1, 1'b1, 1'b1);
            check("hlt_frozen", int'({step, pc_out_n}), 1);
        end
        tick(4'h1, 1'b0, 1'b0, 1'b0);
        tick(4'h1, 1'b0, 1'b0, 1'b1);
        check("hlt_cleared", int'({hlt, pc_out_n}), 0);
        tick(4'h2, 1'b0, 1'b0, 1'b1);
        // ADD aborted in T3
        for (int k = 1; k <= 3; k++) tick(4'h2, 1'b0, 1'b0, 1'b1);
        check("add_t3", int'(step), 3);
        tick(4'h2, 1'b0, 1'b0, 1'b0);
        check("abort_mask", int'(act), 0);
        check("abort_step", int'(step), 0);
        tick(4'h0, 1'b0, 1'b0, 1'b1);
        check("abort_release_step", int'(step), 0);

        halt_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            model_edge();
            #1;
            carry_flag = 1'($urandom_range(0, 1));
            zero_flag  = 1'($urandom_range(0, 1));
            if (m_hlt) halt_cnt++;
            if (!clear_n) clear_n = 1'b1;
            else if (halt_cnt > 4 || $urandom_range(0, 199) == 0) begin
                clear_n = 1'b0; halt_cnt = 0;
            end
            if (m_step == 0) begin
                opcode = 4'($urandom_range(0, 15));
                if (opcode == 4'hF && $urandom_range(0, 3) != 0) opcode = 4'h2;
            end
            #2;
            compare();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
